// File: rtl/node_port_io.sv
// Blocking TIS-100 port interface: turns single-cycle read/write requests into
// valid/ack transfers with the four neighbours, including ANY, LAST and NIL ports.
module node_port_io #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rdReq,
  input  logic [2:0]   rdSel,
  input  logic         wrReq,
  input  logic [2:0]   wrSel,
  input  logic [W-1:0] wrData,
  output logic [W-1:0] rdData,
  output logic         rdDone,
  output logic         wrDone,
  output logic         busy,
  output logic [1:0]   lastPort,
  output logic         lastValid,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [3:0]   inValid,
  output logic [3:0]   inAck,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [3:0]   outValid,
  input  logic [3:0]   outAck
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t       state, state_nxt;
  logic [3:0]   tgt_mask;
  logic         tgt_any;
  logic [W-1:0] out_q;
  logic [3:0]   rd_mask, wr_mask, rd_hit, wr_hit;
  logic [1:0]   rd_win, wr_win;
  logic [W-1:0] rd_mux;

  // Target set for a selector; an empty set means the transfer completes as NIL.
  function automatic logic [3:0] sel_mask(input logic [2:0] sel, input logic lv,
                                          input logic [1:0] lp);
    case (sel)
      3'd0, 3'd1, 3'd2, 3'd3: sel_mask = 4'b0001 << sel[1:0];
      3'd4:                   sel_mask = 4'b1111;
      3'd5:                   sel_mask = lv ? (4'b0001 << lp) : 4'b0000;
      default:                sel_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] pick(input logic [3:0] v);
    if (v[0])      pick = 2'd0;
    else if (v[1]) pick = 2'd1;
    else if (v[2]) pick = 2'd2;
    else           pick = 2'd3;
  endfunction

  always_comb begin
    rd_mask = sel_mask(rdSel, lastValid, lastPort);
    wr_mask = sel_mask(wrSel, lastValid, lastPort);
    rd_hit  = inValid & tgt_mask;
    wr_hit  = outAck & outValid;
    rd_win  = pick(rd_hit);
    wr_win  = pick(wr_hit);
    case (rd_win)
      2'd0:    rd_mux = in0;
      2'd1:    rd_mux = in1;
      2'd2:    rd_mux = in2;
      default: rd_mux = in3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rdReq) begin
          if (rd_mask != 4'b0000) state_nxt = RD_WAIT;
        end else if (wrReq) begin
          if (wr_mask != 4'b0000) state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: if (|rd_hit) state_nxt = IDLE;
      WR_WAIT: if (|wr_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdData    <= '0;
      rdDone    <= 1'b0;
      wrDone    <= 1'b0;
      inAck     <= '0;
      out_q     <= '0;
      outValid  <= '0;
      lastPort  <= '0;
      lastValid <= 1'b0;
      tgt_mask  <= '0;
      tgt_any   <= 1'b0;
    end else begin
      rdDone <= 1'b0;
      wrDone <= 1'b0;
      inAck  <= '0;
      case (state)
        IDLE: begin
          if (rdReq) begin
            if (rd_mask == 4'b0000) begin
              rdData <= '0;
              rdDone <= 1'b1;
            end else begin
              tgt_mask <= rd_mask;
              tgt_any  <= (rdSel == 3'd4);
            end
          end else if (wrReq) begin
            if (wr_mask == 4'b0000) begin
              wrDone <= 1'b1;
            end else begin
              out_q    <= wrData;
              outValid <= wr_mask;
              tgt_any  <= (wrSel == 3'd4);
            end
          end
        end
        RD_WAIT: begin
          if (|rd_hit) begin
            rdData        <= rd_mux;
            inAck[rd_win] <= 1'b1;
            rdDone        <= 1'b1;
            if (tgt_any) begin
              lastPort  <= rd_win;
              lastValid <= 1'b1;
            end
          end
        end
        WR_WAIT: begin
          // Simultaneous ANY acks: every acker got a copy, only the lowest is recorded.
          if (|wr_hit) begin
            outValid <= '0;
            wrDone   <= 1'b1;
            if (tgt_any) begin
              lastPort  <= wr_win;
              lastValid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out0 = out_q;
  assign out1 = out_q;
  assign out2 = out_q;
  assign out3 = out_q;

endmodule
